// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: accepts 512-bit blocks, steps the compression rounds and signals
// hash init/update/digest. Define SHA_CTRL_ABORT_EN to add an abort input that drops the current message.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk_valid,
  input  logic             blk_last,
  input  logic             digest_ack,
`ifdef SHA_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             blk_ready,
  output logic             init_hash,
  output logic             wv_load,
  output logic             w_load_en,
  output logic             w_sched_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             hash_update,
  output logic             digest_valid,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] MSG_WORDS   = IDX_W'(16);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_PREP,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic blk_ready;
    logic init_hash;
    logic wv_load;
    logic w_load_en;
    logic w_sched_en;
    logic round_en;
    logic hash_update;
    logic digest_valid;
    logic busy;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  ctrl_t            ctrl_q;

  // Output decode for a given state; applied to the next state so outputs come straight from flops.
  function automatic ctrl_t decode(input state_e s, input logic [IDX_W-1:0] idx);
    ctrl_t c;
    c = '0;
    case (s)
      ST_IDLE:   c.blk_ready = 1'b1;
      ST_INIT:   c.init_hash = 1'b1;
      ST_PREP:   c.wv_load   = 1'b1;
      ST_ROUND: begin
        c.round_en   = 1'b1;
        c.w_load_en  = (idx < MSG_WORDS);
        c.w_sched_en = (idx >= MSG_WORDS);
      end
      ST_UPDATE: c.hash_update  = 1'b1;
      ST_DONE:   c.digest_valid = 1'b1;
      default:   c = '0;
    endcase
    c.busy = (s != ST_IDLE);
    return c;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          last_d  = blk_last;
          state_d = first_q ? ST_INIT : ST_PREP;
        end
      end
      ST_INIT: begin
        first_d = 1'b0;
        state_d = ST_PREP;
      end
      ST_PREP:   state_d = ST_ROUND;
      ST_ROUND: begin
        if (idx_q == LAST_IDX) state_d = ST_UPDATE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_UPDATE: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE: begin
        if (digest_ack) begin
          first_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
`ifdef SHA_CTRL_ABORT_EN
    // Abort drops the message outright: no update, no digest, next block starts a new message.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      first_d = 1'b1;
      last_d  = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over all events.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      ctrl_q  <= decode(ST_IDLE, '0);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      ctrl_q  <= decode(state_d, idx_d);
    end
  end

  assign blk_ready    = ctrl_q.blk_ready;
  assign init_hash    = ctrl_q.init_hash;
  assign wv_load      = ctrl_q.wv_load;
  assign w_load_en    = ctrl_q.w_load_en;
  assign w_sched_en   = ctrl_q.w_sched_en;
  assign round_en     = ctrl_q.round_en;
  assign hash_update  = ctrl_q.hash_update;
  assign digest_valid = ctrl_q.digest_valid;
  assign busy         = ctrl_q.busy;
  assign round_idx    = idx_q;

  a_w_excl: assert property (@(posedge clock) disable iff (reset) !(w_load_en && w_sched_en));
  a_w_rnd:  assert property (@(posedge clock) disable iff (reset) round_en == (w_load_en || w_sched_en));
  a_idx:    assert property (@(posedge clock) disable iff (reset) round_idx <= LAST_IDX);
  a_idx0:   assert property (@(posedge clock) disable iff (reset) !round_en |-> round_idx == '0);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: per-cycle expected output vectors are queued from the
// documented timeline and compared at each negedge.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;

  localparam int K_IDLE = 0, K_INIT = 1, K_PREP = 2, K_ROUND = 3, K_UPDATE = 4, K_DONE = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic blk_valid = 1'b0, blk_last = 1'b0, digest_ack = 1'b0;
`ifdef SHA_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif
  logic blk_ready, init_hash, wv_load, w_load_en, w_sched_en, round_en;
  logic hash_update, digest_valid, busy;
  logic [IDX_W-1:0] round_idx;

  logic [14:0] obs;
  logic [14:0] exp_v;
  logic [14:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clock(clock),
    .reset(reset),
    .blk_valid(blk_valid),
    .blk_last(blk_last),
    .digest_ack(digest_ack),
`ifdef SHA_CTRL_ABORT_EN
    .abort(abort),
`endif
    .blk_ready(blk_ready),
    .init_hash(init_hash),
    .wv_load(wv_load),
    .w_load_en(w_load_en),
    .w_sched_en(w_sched_en),
    .round_en(round_en),
    .round_idx(round_idx),
    .hash_update(hash_update),
    .digest_valid(digest_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // {blk_ready, init_hash, wv_load, w_load_en, w_sched_en, round_en, hash_update, digest_valid, busy, round_idx}
  assign obs = {blk_ready, init_hash, wv_load, w_load_en, w_sched_en, round_en,
                hash_update, digest_valid, busy, round_idx};

  function automatic logic [14:0] ev(input int k, input int idx);
    logic [8:0] f;
    logic [5:0] r;
    f = 9'b0;
    r = 6'd0;
    case (k)
      K_IDLE:   f = 9'b1_0000_0000;
      K_INIT:   f = 9'b0_1000_0001;
      K_PREP:   f = 9'b0_0100_0001;
      K_ROUND: begin
        f = (idx < 16) ? 9'b0_0010_1001 : 9'b0_0001_1001;
        r = 6'(idx);
      end
      K_UPDATE: f = 9'b0_0000_0101;
      K_DONE:   f = 9'b0_0000_0011;
      default:  f = 9'b0;
    endcase
    return {f, r};
  endfunction

  // Expected vectors from the accept cycle (IDLE) through UPDATE for one block.
  task automatic push_block(input bit first);
    sb_q.push_back(ev(K_IDLE, 0));
    if (first) sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int t = 0; t < ROUNDS; t++) sb_q.push_back(ev(K_ROUND, t));
    sb_q.push_back(ev(K_UPDATE, 0));
  endtask

  task automatic clean_reset();
    reset = 1'b1;
    blk_valid = 1'b0; blk_last = 1'b0; digest_ack = 1'b0;
`ifdef SHA_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    blk_valid = 1'b1; blk_last = 1'b1; digest_ack = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(ev(K_IDLE, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset c%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    blk_valid = 1'b0; blk_last = 1'b0; digest_ack = 1'b0;
  endtask

  // Single block; stray ack / toggling valid during rounds when noisy is set.
  task automatic test_single(input bit noisy);
    push_block(1'b1);
    repeat (3) sb_q.push_back(ev(K_DONE, 0));
    sb_q.push_back(ev(K_IDLE, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      blk_valid  = (i == 0);
      blk_last   = (i == 0);
      digest_ack = (i == 70);
      if (noisy && i >= 3 && i <= 66) begin
        blk_valid  = i[0];
        blk_last   = ~i[0];
        digest_ack = (i % 7 == 0);
      end
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single(noisy=%0d) c%0d: got %b want %b", noisy, i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    clean_reset();
  endtask

  task automatic test_back_to_back();
    push_block(1'b1);
    push_block(1'b0);
    repeat (2) sb_q.push_back(ev(K_DONE, 0));
    sb_q.push_back(ev(K_IDLE, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      blk_valid  = (i <= 68);
      blk_last   = (i != 0);
      digest_ack = (i == 136);
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    clean_reset();
  endtask

  task automatic test_mid_reset();
    sb_q.push_back(ev(K_IDLE, 0));
    sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int t = 0; t <= 30; t++) sb_q.push_back(ev(K_ROUND, t));
    sb_q.push_back(ev(K_IDLE, 0));
    sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      blk_valid = (i == 0) || (i == 34);
      blk_last  = 1'b1;
      reset     = (i == 33);
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mid_reset c%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    clean_reset();
  endtask

  task automatic test_done_hold();
    push_block(1'b1);
    repeat (10) sb_q.push_back(ev(K_DONE, 0));
    sb_q.push_back(ev(K_IDLE, 0));
    sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      blk_valid  = (i == 0) || (i >= 68 && i <= 78);
      blk_last   = 1'b1;
      digest_ack = (i == 77);
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL done_hold c%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    clean_reset();
  endtask

`ifdef SHA_CTRL_ABORT_EN
  task automatic test_abort();
    sb_q.push_back(ev(K_IDLE, 0));
    sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int t = 0; t <= 10; t++) sb_q.push_back(ev(K_ROUND, t));
    repeat (2) sb_q.push_back(ev(K_IDLE, 0));
    sb_q.push_back(ev(K_INIT, 0));
    sb_q.push_back(ev(K_PREP, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      abort     = (i == 0) || (i == 13);
      blk_valid = (i == 0) || (i == 15);
      blk_last  = 1'b1;
      @(negedge clock);
      exp_v = sb_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL abort c%0d: got %b want %b", i, obs, exp_v);
      end
      @(posedge clock); #1;
    end
    clean_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single(1'b0);
    test_back_to_back();
    test_mid_reset();
    test_done_hold();
    test_single(1'b1);
`ifdef SHA_CTRL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Control FSM that sequences the SHA-256 datapath for one or more 512-bit blocks of a message.
- Accepts a block-ready handshake and loads the initial hash on the first block of each message.
- Steps 64 compression rounds, issuing message-schedule and round enables plus the round index (also the K-ROM address).
- Commits the intermediate hash after each block and presents digest-valid after the last block.
- Sits between the message buffer and the W-schedule/compression datapath; replaces ad-hoc AND-ed start enables.

Parameters:
ROUNDS, 64, number of compression rounds per block (reduced values are for simulation only; must be ≥17)
IDX_W, 6, width of round_idx; must satisfy 2^IDX_W ≥ ROUNDS

Ports:
clock  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
blk_valid  input  1  message buffer holds a complete 16-word block
blk_last  input  1  block is final block of message; sampled with blk_valid&&blk_ready
blk_ready  output  1  controller accepts a block this cycle
init_hash  output  1  load H0..H7 with SHA-256 IV
wv_load  output  1  load working vars a..h from H0..H7
w_load_en  output  1  round uses message word W[t]=M[t] (t<16)
w_sched_en  output  1  round computes W[t] from schedule (t≥16)
round_en  output  1  compression round active this cycle
round_idx  output  IDX_W  current round t, also K-ROM address
hash_update  output  1  H[i] <= H[i] + working var (one cycle)
digest_valid  output  1  H0..H7 holds final digest
digest_ack  input  1  consumer has taken digest
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. On reset state=IDLE, round_idx=0, first-block flag=1, last flag=0; all outputs 0 except blk_ready=1. Reset has priority over every other event, including mid-round and in DONE.
- Outputs are Moore, decoded from registered state and counter; no combinational path from inputs to outputs.
- States:
  - IDLE: blk_ready=1. On blk_valid, capture blk_last; go to INIT if first-block flag, else PREP.
  - INIT: 1 cycle, init_hash=1, clear first-block flag, go to PREP.
  - PREP: 1 cycle, wv_load=1, round_idx=0, go to ROUND.
  - ROUND: round_en=1; w_load_en=1 when round_idx<16, w_sched_en=1 otherwise (mutually exclusive). round_idx increments each cycle. At round_idx==ROUNDS-1, go to UPDATE; round_idx returns to 0.
  - UPDATE: 1 cycle, hash_update=1. If last flag, go to DONE; else go to IDLE.
  - DONE: digest_valid=1, held until digest_ack. On digest_ack, set first-block flag=1 and go to IDLE.
- digest_ack outside DONE is ignored. blk_valid outside IDLE is ignored, and the block is not consumed.
- Latency, with accept at cycle 0:
  - First block: INIT c1, PREP c2, rounds c3..c(2+ROUNDS), UPDATE c(3+ROUNDS), digest_valid from c(4+ROUNDS) for the last block.
  - Subsequent block: PREP c1, ROUND c2.., UPDATE c(2+ROUNDS).
- Back-to-back: blk_valid held high in IDLE after a non-last UPDATE is accepted on the first IDLE cycle. This gives a one-cycle bubble; a block cannot be accepted in the UPDATE cycle.
- round_idx never exceeds ROUNDS-1. It holds 0 in all non-ROUND states.

Optional Feature:
SHA_CTRL_ABORT_EN:
- When defined: adds input abort (1 bit). abort high in any state other than IDLE returns the FSM to IDLE next cycle with round_idx=0 and first-block flag=1. No hash_update or digest_valid is produced for the aborted message. abort in IDLE has no effect.
- When undefined: no abort port; the FSM can leave a message only through reset.

Test Plan:
1. Reset then single block, blk_valid=1, blk_last=1 at c0 -> init_hash at c1, wv_load c2, round_en c3..c66 with round_idx 0..63, w_load_en c3..c18, w_sched_en c19..c66, hash_update c67, digest_valid c68 until digest_ack.
2. Two-block message, block A blk_last=0 then block B blk_last=1 held valid -> A: hash_update c67, IDLE c68, B accepted c68 with no init_hash, PREP c69, rounds c70..c133, hash_update c134, digest_valid c135.
3. reset asserted at round_idx=30 -> next cycle IDLE, blk_ready=1, all enables 0. Next block triggers init_hash.
4. digest_ack held 0 for 10 cycles in DONE with blk_valid=1 -> digest_valid stays 1, blk_ready=0, no block accepted. Ack -> IDLE, next message gets init_hash.
5. Stray digest_ack during ROUND, and blk_valid toggling during ROUND -> no state or counter disturbance; round sequence identical to scenario 1.
6. SHA_CTRL_ABORT_EN defined, abort at round_idx=10 of a last block -> IDLE next cycle, no hash_update or digest_valid. Next accepted block asserts init_hash.
